main_mem_ctrl: RTL and testbench
================================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, cycles from request acceptance to ready pulse (legal range 1..255).
REQ-002 The block SHALL have parameter MEM_LINES, default 1024, number of 128-bit lines in the backing array (power of two).
REQ-003 The block SHALL have port clk_i, input, 1, clock.
REQ-004 The block SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port mem_req_i, input, mem_req_type, L2 miss/writeback request: addr 32, data 128, rw, valid.
REQ-006 The block SHALL have port mem_data_o, output, mem_data_type, response: data 128, ready.
REQ-007 The block SHALL have port busy_o, output, 1, high while a request is pending.
REQ-008 The block SHALL have port drop_o, output, 1, sticky flag: a request arrived while busy.
REQ-009 The block SHALL have ports no_rd_o and no_wr_o, output, 32 each: accepted read and write counts.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-011 A request SHALL be accepted on any rising edge where mem_req_i.valid=1 and the state is IDLE or RESP; acceptance samples addr, data and rw into holding registers, loads the down-counter with LATENCY-1 and enters WAIT (or RESP directly when LATENCY=1).
REQ-012 Valid is a single-cycle pulse; the block SHALL NOT require valid to be held after acceptance.
REQ-013 WAIT SHALL decrement the counter each cycle and move to RESP when the counter is 0, so ready rises exactly LATENCY cycles after the acceptance edge.
REQ-014 RESP SHALL assert mem_data_o.ready for exactly one cycle, then return to IDLE unless a new request is accepted in that same cycle (back-to-back: writeback ready followed by allocate read).
REQ-015 The line index SHALL be addr[log2(MEM_LINES)+3:4]; addr[3:0] and upper bits beyond the index SHALL be ignored.
REQ-016 A read SHALL drive mem_data_o.data with the array line during the RESP cycle; a write SHALL commit the held data to the array on the RESP edge, and mem_data_o.data SHALL then be 0.
REQ-017 mem_data_o.data SHALL be 0 whenever ready=0.
REQ-018 A read accepted in the RESP cycle of a write to the same line SHALL return the newly written data.
REQ-019 valid=1 while in WAIT SHALL be ignored (the request is not queued) and SHALL set drop_o until reset.
REQ-020 busy_o SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-021 no_rd_o/no_wr_o SHALL increment by 1 on each accepted read/write and wrap from 0xFFFFFFFF to 0; dropped requests SHALL NOT be counted.

Reset
REQ-022 Asserting rst_ni low SHALL immediately force state IDLE, counter 0, ready 0, data 0, busy_o 0, drop_o 0, and both counters 0.
REQ-023 Reset mid-WAIT SHALL abandon the pending request: no ready pulse, and a pending write is not committed.
REQ-024 Array contents SHALL NOT be affected by reset.

Configuration
REQ-025 Macro MAIN_MEM_STATS_EN defined: no_rd_o, no_wr_o and drop_o are implemented as specified.
REQ-026 Macro MAIN_MEM_STATS_EN undefined: no counter or drop registers exist; no_rd_o, no_wr_o and drop_o are tied to 0; all other behaviour is identical.

Structure
REQ-027 mem_req_type, mem_data_type, MEM_LATENCY and MEM_LINES SHALL live in package cache_def.
REQ-028 The backing store SHALL be sub-module main_mem_array: single port, synchronous write, combinational read, 128-bit wide, MEM_LINES deep.
REQ-029 The counters SHALL reuse adder_32bit.

Verification
REQ-030 Write then read, LATENCY=4:
- Stimulus: write addr 0x0000_0120, data 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D; then read 0x0000_0128.
- Response: ready at acceptance+4 for each request; the read returns the written line; no_wr_o=1, no_rd_o=1.
REQ-031 Back-to-back:
- Stimulus: pulse a write to line 5, then pulse a read to line 5 in the write's ready cycle.
- Response: the read is accepted; its ready arrives 4 cycles later with the new data; drop_o=0.
REQ-032 Drop:
- Stimulus: pulse valid 2 cycles after an accepted read.
- Response: drop_o=1; exactly one ready pulse; no_rd_o=1.
REQ-033 LATENCY=1:
- Stimulus: read at edge N.
- Response: ready high during cycle N+1 only; busy_o low at N+2.
REQ-034 Reset mid-operation:
- Stimulus: assert rst_ni low in WAIT of a write to line 7, then release and read line 7.
- Response: no ready pulse from the abandoned write; the read returns the old contents; counters read 0 then 1.
REQ-035 Stats off:
- Stimulus: build without MAIN_MEM_STATS_EN and repeat REQ-032.
- Response: no_rd_o, no_wr_o and drop_o stay 0; ready timing is unchanged.

Source files
------------

// File: rtl/cache_def.sv
// Shared types and default sizing for the main memory controller and its callers.
package cache_def;

  localparam int MEM_LATENCY = 4;
  localparam int MEM_LINES   = 1024;

  // rw = 1 selects a write (L2 writeback); rw = 0 selects a read (L2 miss fill).
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit adder shared by the controller's counters; the sum wraps modulo 2^32.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/main_mem_array.sv
// Single-port backing store of 128-bit lines: synchronous write, combinational read.
module main_mem_array #(
  parameter int LINES = 1024,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [127:0]     wdata,
  output logic [127:0]     rdata
);

  logic [127:0] mem [LINES];

  // Contents are deliberately never reset so data survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency main memory controller behind the L2: one request in flight, one-cycle ready pulse.
// Optional statistics (read/write counters, sticky drop flag) are built when MAIN_MEM_STATS_EN is defined.
module main_mem_ctrl
  import cache_def::mem_req_type, cache_def::mem_data_type, cache_def::mem_state_e;
  import cache_def::IDLE, cache_def::WAIT, cache_def::RESP;
#(
  parameter int LATENCY   = cache_def::MEM_LATENCY,
  parameter int MEM_LINES = cache_def::MEM_LINES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_req_type  mem_req_i,
  output mem_data_type mem_data_o,
  output logic         busy_o,
  output logic         drop_o,
  output logic [31:0]  no_rd_o,
  output logic [31:0]  no_wr_o
);

  localparam int         IDX_W    = $clog2(MEM_LINES);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  mem_state_e       state;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     wdata_q;
  logic             rw_q;
  logic [127:0]     rdata;
  logic             accept;
  logic             commit;
  logic [31:0]      cnt_dec;
  logic             unused_addr;
  logic             unused_cnt_hi;

  // A new request can be taken when idle or while presenting the previous response.
  assign accept = mem_req_i.valid && (state != WAIT);
  assign commit = (state == RESP) && rw_q;

  assign unused_addr   = ^{mem_req_i.addr[31:IDX_W+4], mem_req_i.addr[3:0]};
  assign unused_cnt_hi = ^cnt_dec[31:8];

  // Latency down-counter decrement shares the common adder (adding all-ones subtracts one).
  adder_32bit u_cnt_dec (
    .a   ({24'd0, cnt}),
    .b   (32'hFFFF_FFFF),
    .sum (cnt_dec)
  );

  main_mem_array #(
    .LINES (MEM_LINES),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .we    (commit),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Request FSM: accepting samples the request so valid only needs to be a single-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            idx_q   <= mem_req_i.addr[IDX_W+3:4];
            wdata_q <= mem_req_i.data;
            rw_q    <= mem_req_i.rw;
            cnt     <= LAT_LOAD;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt_dec[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is taken straight from the array so a write committed on the same edge is visible.
  always_comb begin
    mem_data_o = '0;
    if (state == RESP) begin
      mem_data_o.ready = 1'b1;
      if (!rw_q) begin
        mem_data_o.data = rdata;
      end
    end
  end

  assign busy_o = (state != IDLE);

`ifdef MAIN_MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] rd_next;
  logic [31:0] wr_next;
  logic        drop_q;

  adder_32bit u_rd_add (
    .a   (rd_cnt),
    .b   (32'd1),
    .sum (rd_next)
  );

  adder_32bit u_wr_add (
    .a   (wr_cnt),
    .b   (32'd1),
    .sum (wr_next)
  );

  // Only accepted requests are counted; a request arriving mid-wait is lost and flagged instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      drop_q <= 1'b0;
    end else begin
      if (accept && !mem_req_i.rw) begin
        rd_cnt <= rd_next;
      end
      if (accept && mem_req_i.rw) begin
        wr_cnt <= wr_next;
      end
      if (mem_req_i.valid && (state == WAIT)) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign no_rd_o = rd_cnt;
  assign no_wr_o = wr_cnt;
  assign drop_o  = drop_q;
`else
  assign no_rd_o = '0;
  assign no_wr_o = '0;
  assign drop_o  = 1'b0;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: table-driven transactions at LATENCY=4 plus hand-written corner cases.
module tb_main_mem_ctrl;
  import cache_def::*;

`ifdef MAIN_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D4 = 128'h0BADC0DE_FEEDFACE_12345678_9ABCDEF0;
  localparam logic [127:0] D5 = 128'h00000007_00000007_00000007_00000007;
  localparam logic [127:0] D6 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] D7 = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
  localparam logic [127:0] D8 = 128'hC001D00D_00C0FFEE_BAADF00D_FACEB00C;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  mem_req_type  req;
  mem_data_type resp;
  logic         busy;
  logic         drop;
  logic [31:0]  no_rd;
  logic [31:0]  no_wr;
  mem_req_type  req1;
  mem_data_type resp1;
  logic         busy1;
  logic         drop1;
  logic [31:0]  no_rd1;
  logic [31:0]  no_wr1;

  int   checks = 0;
  int   fails  = 0;
  vec_t vecs[7];

  main_mem_ctrl #(.LATENCY(4), .MEM_LINES(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_data_o(resp),
    .busy_o(busy), .drop_o(drop), .no_rd_o(no_rd), .no_wr_o(no_wr)
  );

  main_mem_ctrl #(.LATENCY(1), .MEM_LINES(64)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req1), .mem_data_o(resp1),
    .busy_o(busy1), .drop_o(drop1), .no_rd_o(no_rd1), .no_wr_o(no_wr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives a one-cycle valid pulse; returns just after the edge that samples it.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    req.valid = 1'b1;
    req.rw    = rw;
    req.addr  = addr;
    req.data  = data;
    tick();
    req = '0;
  endtask

  task automatic waitReady(output int n);
    bit found;
    found = 1'b0;
    n = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (resp.ready) begin
        n = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic countReady(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (resp.ready) pulses++;
    end
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_no_rd", 128'(no_rd), 128'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0] = '{1'b1, 32'h0000_0120, D1, 128'd0};
    vecs[1] = '{1'b0, 32'h0000_0128, 128'd0, D1};
    vecs[2] = '{1'b1, 32'h0000_0350, D2, 128'd0};
    vecs[3] = '{1'b0, 32'hFFFF_C35F, 128'd0, D2};
    vecs[4] = '{1'b1, 32'h0000_4000, D3, 128'd0};
    vecs[5] = '{1'b0, 32'h0000_000C, 128'd0, D3};
    vecs[6] = '{1'b0, 32'h8000_0124, 128'd0, D1};

    rst_n = 1'b0;
    req   = '0;
    req1  = '0;
    tick();
    tick();
    checkOutput("reset_ready", 128'(resp.ready), 128'd0);
    checkOutput("reset_data", resp.data, 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_drop", 128'(drop), 128'd0);
    checkOutput("reset_no_rd", 128'(no_rd), 128'd0);
    checkOutput("reset_no_wr", 128'(no_wr), 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("vec%0d_busy", i), 128'(busy), 128'd1);
      waitReady(n);
      checkOutput($sformatf("vec%0d_latency", i), 128'(n), 128'd4);
      checkOutput($sformatf("vec%0d_data", i), resp.data, vecs[i].exp);
      tick();
      checkOutput($sformatf("vec%0d_ready_after", i), 128'(resp.ready), 128'd0);
      checkOutput($sformatf("vec%0d_busy_after", i), 128'(busy), 128'd0);
      checkOutput($sformatf("vec%0d_data_after", i), resp.data, 128'd0);
    end
    checkOutput("table_no_wr", 128'(no_wr), 128'(st(32'd3)));
    checkOutput("table_no_rd", 128'(no_rd), 128'(st(32'd4)));
    checkOutput("table_drop", 128'(drop), 128'd0);

    // Back-to-back: read of line 5 accepted in the write's ready cycle.
    applyStimulus(1'b1, 32'h0000_0050, D4);
    waitReady(n);
    checkOutput("b2b_wr_latency", 128'(n), 128'd4);
    applyStimulus(1'b0, 32'h0000_0050, 128'd0);
    checkOutput("b2b_busy", 128'(busy), 128'd1);
    waitReady(n);
    checkOutput("b2b_rd_latency", 128'(n), 128'd4);
    checkOutput("b2b_rd_data", resp.data, D4);
    checkOutput("b2b_drop", 128'(drop), 128'd0);
    checkOutput("b2b_no_wr", 128'(no_wr), 128'(st(32'd4)));
    checkOutput("b2b_no_rd", 128'(no_rd), 128'(st(32'd5)));
    tick();

    // Drop: a write pulsed two cycles after an accepted read is ignored.
    pulseReset();
    applyStimulus(1'b0, 32'h0000_0120, 128'd0);
    tick();
    applyStimulus(1'b1, 32'h0000_0120, D6);
    waitReady(n);
    checkOutput("drop_latency", 128'(n), 128'd2);
    checkOutput("drop_rd_data", resp.data, D1);
    countReady(10, pulses);
    checkOutput("drop_extra_ready", 128'(pulses), 128'd0);
    checkOutput("drop_flag", 128'(drop), 128'(STATS));
    checkOutput("drop_no_rd", 128'(no_rd), 128'(st(32'd1)));
    checkOutput("drop_no_wr", 128'(no_wr), 128'd0);
    checkOutput("drop_busy", 128'(busy), 128'd0);

    // Reset in the middle of a write to line 7 must leave the old contents.
    applyStimulus(1'b1, 32'h0000_0070, D5);
    waitReady(n);
    checkOutput("old7_latency", 128'(n), 128'd4);
    tick();
    pulseReset();
    checkOutput("mid_no_wr0", 128'(no_wr), 128'd0);
    checkOutput("mid_drop0", 128'(drop), 128'd0);
    applyStimulus(1'b1, 32'h0000_0074, D6);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_async", 128'(busy), 128'd0);
    checkOutput("mid_ready_async", 128'(resp.ready), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    countReady(6, pulses);
    checkOutput("mid_no_ready", 128'(pulses), 128'd0);
    applyStimulus(1'b0, 32'h0000_007C, 128'd0);
    waitReady(n);
    checkOutput("mid_rd_latency", 128'(n), 128'd4);
    checkOutput("mid_rd_data", resp.data, D5);
    checkOutput("mid_no_rd1", 128'(no_rd), 128'(st(32'd1)));
    checkOutput("mid_no_wr1", 128'(no_wr), 128'd0);
    tick();

    // LATENCY=1 instance: ready right after acceptance, idle the cycle after.
    req1 = '{addr: 32'h0000_0030, data: D7, rw: 1'b1, valid: 1'b1};
    tick();
    req1 = '0;
    checkOutput("l1_wr_ready", 128'(resp1.ready), 128'd1);
    checkOutput("l1_wr_data", resp1.data, 128'd0);
    checkOutput("l1_wr_busy", 128'(busy1), 128'd1);
    tick();
    checkOutput("l1_wr_ready_after", 128'(resp1.ready), 128'd0);
    checkOutput("l1_wr_busy_after", 128'(busy1), 128'd0);
    req1 = '{addr: 32'h0000_0030, data: 128'd0, rw: 1'b0, valid: 1'b1};
    tick();
    req1 = '0;
    checkOutput("l1_rd_ready", 128'(resp1.ready), 128'd1);
    checkOutput("l1_rd_data", resp1.data, D7);
    tick();
    checkOutput("l1_rd_ready_after", 128'(resp1.ready), 128'd0);
    checkOutput("l1_rd_busy_after", 128'(busy1), 128'd0);
    req1 = '{addr: 32'h0000_0090, data: D8, rw: 1'b1, valid: 1'b1};
    tick();
    checkOutput("l1_b2b_wr_ready", 128'(resp1.ready), 128'd1);
    req1 = '{addr: 32'h0000_0090, data: 128'd0, rw: 1'b0, valid: 1'b1};
    tick();
    req1 = '0;
    checkOutput("l1_b2b_rd_ready", 128'(resp1.ready), 128'd1);
    checkOutput("l1_b2b_rd_data", resp1.data, D8);
    tick();
    checkOutput("l1_b2b_ready_after", 128'(resp1.ready), 128'd0);
    checkOutput("l1_b2b_busy_after", 128'(busy1), 128'd0);
    checkOutput("l1_no_wr", 128'(no_wr1), 128'(st(32'd2)));
    checkOutput("l1_no_rd", 128'(no_rd1), 128'(st(32'd2)));
    checkOutput("l1_drop", 128'(drop1), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
